// File: rtl/pixel_unpacker.sv
// Unpacks 32-bit G,B,R byte-packed stream words (3 words -> 4 pixels) into one registered 24-bit pixel per beat.
// Optional saturating framing-error counter enabled by defining PIXEL_UNPACKER_ERR_CNT_EN.
module pixel_unpacker #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [31:0]          in_stream_tdata,
    input  logic [3:0]           in_stream_tkeep,
    input  logic                 in_stream_tlast,
    input  logic                 in_stream_tuser,
    input  logic                 in_stream_tvalid,
    output logic                 in_stream_tready,
    output logic [7:0]           r,
    output logic [7:0]           g,
    output logic [7:0]           b,
    output logic                 sof,
    output logic                 eol,
    output logic                 valid,
    input  logic                 out_ready,
    output logic                 sync_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

    phase_t          phase_q, phase_d;
    logic [2:0][7:0] hold_q, hold_d;
    logic            eol_pend_q, eol_pend_d;
    logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;
    logic            sof_q, sof_d, eol_q, eol_d, valid_q, valid_d;
    logic            serr_q, serr_d;

    logic            free, accept, resync, early_last;
    phase_t          dec_phase;
    logic [3:0][7:0] bytes;
    logic            unused_tkeep;

    assign unused_tkeep     = ^in_stream_tkeep;
    assign bytes            = in_stream_tdata;
    assign free             = ~valid_q | out_ready;
    assign in_stream_tready = aresetn & free & (phase_q != P3);
    assign accept           = in_stream_tvalid & in_stream_tready;

    always_comb begin
        phase_d    = phase_q;
        hold_d     = hold_q;
        eol_pend_d = eol_pend_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        sof_d      = sof_q;
        eol_d      = eol_q;
        valid_d    = valid_q & ~out_ready;
        resync     = 1'b0;
        early_last = 1'b0;
        dec_phase  = phase_q;

        if (accept) begin
            // A frame start in mid-group realigns the decoder onto this word.
            resync     = in_stream_tuser & ((phase_q == P1) | (phase_q == P2));
            dec_phase  = resync ? P0 : phase_q;
            valid_d    = 1'b1;
            sof_d      = 1'b0;
            eol_d      = 1'b0;
            eol_pend_d = 1'b0;
            case (dec_phase)
                P0: begin
                    g_d       = bytes[0];
                    b_d       = bytes[1];
                    r_d       = bytes[2];
                    hold_d    = '0;
                    hold_d[0] = bytes[3];
                    sof_d     = in_stream_tuser;
                    phase_d   = P1;
                end
                P1: begin
                    g_d       = hold_q[0];
                    b_d       = bytes[0];
                    r_d       = bytes[1];
                    hold_d    = '0;
                    hold_d[0] = bytes[2];
                    hold_d[1] = bytes[3];
                    phase_d   = P2;
                end
                P2: begin
                    g_d        = hold_q[0];
                    b_d        = hold_q[1];
                    r_d        = bytes[0];
                    hold_d     = {bytes[3], bytes[2], bytes[1]};
                    eol_pend_d = in_stream_tlast;
                    phase_d    = P3;
                end
                default: begin
                    phase_d = P0;
                end
            endcase
            // A line ending before a full 4-pixel group closes the line on this pixel.
            if (in_stream_tlast && (dec_phase != P2)) begin
                early_last = 1'b1;
                eol_d      = 1'b1;
                hold_d     = '0;
                phase_d    = P0;
            end
        end else if (free && (phase_q == P3)) begin
            g_d        = hold_q[0];
            b_d        = hold_q[1];
            r_d        = hold_q[2];
            sof_d      = 1'b0;
            eol_d      = eol_pend_q;
            eol_pend_d = 1'b0;
            valid_d    = 1'b1;
            phase_d    = P0;
        end

        serr_d = resync | early_last;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            phase_q    <= P0;
            hold_q     <= '0;
            eol_pend_q <= 1'b0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            valid_q    <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            hold_q     <= hold_d;
            eol_pend_q <= eol_pend_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            valid_q    <= valid_d;
            serr_q     <= serr_d;
        end
    end

`ifdef PIXEL_UNPACKER_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err_cnt_q <= '0;
        end else if (serr_d && !(&err_cnt_q)) begin
            err_cnt_q <= err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

    assign r        = r_q;
    assign g        = g_q;
    assign b        = b_q;
    assign sof      = sof_q;
    assign eol      = eol_q;
    assign valid    = valid_q;
    assign sync_err = serr_q;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed bench for pixel_unpacker: cycle vector table plus back-pressure, reset and counter sequences.
module tb_pixel_unpacker;
    localparam int W = 2;

`ifdef PIXEL_UNPACKER_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [31:0]  tdata;
    logic [3:0]   tkeep;
    logic         tlast, tuser, tvalid, tready;
    logic [7:0]   r, g, b;
    logic         sof, eol, valid, out_ready, sync_err;
    logic [W-1:0] err_count;

    always #5 aclk = ~aclk;

    pixel_unpacker #(.ERR_CNT_W(W)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .in_stream_tdata  (tdata),
        .in_stream_tkeep  (tkeep),
        .in_stream_tlast  (tlast),
        .in_stream_tuser  (tuser),
        .in_stream_tvalid (tvalid),
        .in_stream_tready (tready),
        .r                (r),
        .g                (g),
        .b                (b),
        .sof              (sof),
        .eol              (eol),
        .valid            (valid),
        .out_ready        (out_ready),
        .sync_err         (sync_err),
        .err_count        (err_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          tv;
        logic [31:0] d;
        bit          tu;
        bit          tl;
        bit          ex_rdy;
        bit          ex_vld;
        logic [7:0]  er, eg, eb;
        bit          esof, eeol, eserr;
        int          errs;
    } vec_t;

    function automatic vec_t mk(bit tv, logic [31:0] d, bit tu, bit tl, bit rdy, bit vld,
                                logic [7:0] er, logic [7:0] eg, logic [7:0] eb,
                                bit esof, bit eeol, bit eserr, int errs);
        vec_t v;
        v.tv = tv; v.d = d; v.tu = tu; v.tl = tl; v.ex_rdy = rdy; v.ex_vld = vld;
        v.er = er; v.eg = eg; v.eb = eb; v.esof = esof; v.eeol = eeol; v.eserr = eserr;
        v.errs = errs;
        return v;
    endfunction

    function automatic int exp_cnt(int e);
        if (!CNT_EN) return 0;
        return (e > 3) ? 3 : e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " valid"}, {31'd0, valid}, 32'd0);
        check({tag, " rgb"}, {8'd0, r, g, b}, 32'd0);
        check({tag, " sof/eol"}, {30'd0, sof, eol}, 32'd0);
        check({tag, " sync_err"}, {31'd0, sync_err}, 32'd0);
        check({tag, " err_count"}, {30'd0, err_count}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        tvalid  = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // Nominal line driven with a repeating out_ready pattern (bit i used in cycle i mod 4).
    task automatic run_line(input logic [3:0] pat, input string tag);
        logic [31:0] w[3];
        logic [23:0] ep[4];
        logic [1:0]  fl[4];
        int          wi, pi, cyc;
        bit          acc;
        w[0] = 32'h03020100; w[1] = 32'h07060504; w[2] = 32'h0B0A0908;
        ep[0] = 24'h020001; ep[1] = 24'h050304; ep[2] = 24'h080607; ep[3] = 24'h0B090A;
        fl[0] = 2'b10; fl[1] = 2'b00; fl[2] = 2'b00; fl[3] = 2'b01;
        wi = 0; pi = 0; cyc = 0;
        while (pi < 4 && cyc < 60) begin
            @(negedge aclk);
            out_ready = pat[cyc % 4];
            if (wi < 3) begin
                tvalid = 1'b1;
                tdata  = w[wi];
                tuser  = (wi == 0);
                tlast  = (wi == 2);
            end else begin
                tvalid = 1'b0;
                tuser  = 1'b0;
                tlast  = 1'b0;
            end
            #1;
            if (valid && !out_ready) check({tag, " stall tready"}, {31'd0, tready}, 32'd0);
            acc = tvalid && tready;
            if (valid && out_ready) begin
                check($sformatf("%s pixel%0d rgb", tag, pi), {8'd0, r, g, b}, {8'd0, ep[pi]});
                check($sformatf("%s pixel%0d sof/eol", tag, pi), {30'd0, sof, eol}, {30'd0, fl[pi]});
                pi++;
            end
            @(posedge aclk);
            if (acc) wi++;
            cyc++;
        end
        check({tag, " pixel count"}, pi, 4);
        check({tag, " words consumed"}, wi, 3);
        #1;
        check({tag, " no extra pixel"}, {31'd0, valid}, 32'd0);
        @(negedge aclk);
        tvalid    = 1'b0;
        tuser     = 1'b0;
        tlast     = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[15];

        // Nominal line, then resync, early tlast in P1 and P0, and combined tuser+tlast.
        vt[0]  = mk(1, 32'h03020100, 1, 0, 1, 1, 8'h02, 8'h00, 8'h01, 1, 0, 0, 0);
        vt[1]  = mk(1, 32'h07060504, 0, 0, 1, 1, 8'h05, 8'h03, 8'h04, 0, 0, 0, 0);
        vt[2]  = mk(1, 32'h0B0A0908, 0, 1, 1, 1, 8'h08, 8'h06, 8'h07, 0, 0, 0, 0);
        vt[3]  = mk(0, 32'h0,        0, 0, 0, 1, 8'h0B, 8'h09, 8'h0A, 0, 1, 0, 0);
        vt[4]  = mk(0, 32'h0,        0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        vt[5]  = mk(1, 32'h03020100, 0, 0, 1, 1, 8'h02, 8'h00, 8'h01, 0, 0, 0, 0);
        vt[6]  = mk(1, 32'h77665544, 1, 0, 1, 1, 8'h66, 8'h44, 8'h55, 1, 0, 1, 1);
        vt[7]  = mk(0, 32'h0,        0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
        vt[8]  = mk(1, 32'h0B0A0908, 0, 1, 1, 1, 8'h09, 8'h77, 8'h08, 0, 1, 1, 2);
        vt[9]  = mk(0, 32'h0,        0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2);
        vt[10] = mk(1, 32'h03020100, 0, 1, 1, 1, 8'h02, 8'h00, 8'h01, 0, 1, 1, 3);
        vt[11] = mk(0, 32'h0,        0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 3);
        vt[12] = mk(1, 32'h03020100, 0, 0, 1, 1, 8'h02, 8'h00, 8'h01, 0, 0, 0, 3);
        vt[13] = mk(1, 32'h33221100, 1, 1, 1, 1, 8'h22, 8'h00, 8'h11, 1, 1, 1, 4);
        vt[14] = mk(0, 32'h0,        0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 4);

        aresetn   = 1'b0;
        tdata     = 32'h0;
        tkeep     = 4'h0;
        tlast     = 1'b0;
        tuser     = 1'b0;
        tvalid    = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        check("reset tready", {31'd0, tready}, 32'd0);
        check_all_zero("reset");
        @(negedge aclk);
        aresetn = 1'b1;
        tvalid  = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge aclk);
            tvalid    = vt[i].tv;
            tdata     = vt[i].d;
            tuser     = vt[i].tu;
            tlast     = vt[i].tl;
            out_ready = 1'b1;
            #1;
            check($sformatf("vec%0d tready", i), {31'd0, tready}, {31'd0, vt[i].ex_rdy});
            @(posedge aclk);
            #1;
            check($sformatf("vec%0d valid", i), {31'd0, valid}, {31'd0, vt[i].ex_vld});
            if (vt[i].ex_vld) begin
                check($sformatf("vec%0d rgb", i), {8'd0, r, g, b}, {8'd0, vt[i].er, vt[i].eg, vt[i].eb});
                check($sformatf("vec%0d sof/eol", i), {30'd0, sof, eol}, {30'd0, vt[i].esof, vt[i].eeol});
            end
            check($sformatf("vec%0d sync_err", i), {31'd0, sync_err}, {31'd0, vt[i].eserr});
            check($sformatf("vec%0d err_count", i), {30'd0, err_count}, exp_cnt(vt[i].errs));
        end
        @(negedge aclk);
        tvalid = 1'b0;

        do_reset();
        run_line(4'b1001, "backpressure");

        do_reset();
        run_line(4'b1111, "full rate");

        // Reset in the middle of a group, then a clean line.
        @(negedge aclk);
        tvalid = 1'b1; tdata = 32'h03020100; tuser = 1'b1; tlast = 1'b0;
        @(negedge aclk);
        tdata = 32'h07060504; tuser = 1'b0;
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("midrst tready", {31'd0, tready}, 32'd0);
        @(posedge aclk);
        #1;
        check_all_zero("midrst");
        @(negedge aclk);
        aresetn = 1'b1;
        tvalid  = 1'b0;
        run_line(4'b1111, "after reset");

        // Repeated early-tlast errors drive the counter to saturation.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            @(negedge aclk);
            tvalid = 1'b1; tdata = 32'h03020100; tuser = 1'b0; tlast = 1'b1;
            @(posedge aclk);
            #1;
            check($sformatf("sat%0d sync_err", k), {31'd0, sync_err}, 32'd1);
            check($sformatf("sat%0d err_count", k), {30'd0, err_count}, exp_cnt(k));
            @(negedge aclk);
            tvalid = 1'b0; tlast = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_unpacker.md
# pixel_unpacker

Converts a 32-bit AXI4-Stream video stream into one 24-bit RGB pixel per beat, with a valid/ready handshake. It is the inverse of the stream packing used on the video output path. Every three 32-bit words carry four pixels, with bytes in G,B,R order per pixel, starting at byte 0. The block sits between a DMA/stream source and pixel-domain consumers such as the ray tracer's frame compare and test checkers. It restores start-of-frame and end-of-line markers per pixel.

## Interface
- ERR_CNT_W, 16, width of the framing-error counter.

- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- in_stream_tdata  in  32  packed pixel bytes; byte0 = bits[7:0].
- in_stream_tkeep  in  4  ignored; all lanes are treated as valid.
- in_stream_tlast  in  1  last word of a line.
- in_stream_tuser  in  1  first word of a frame.
- in_stream_tvalid  in  1  word valid.
- in_stream_tready  out  1  word accepted when high with tvalid.
- r, g, b  out  8 each  pixel colour, registered.
- sof  out  1  pixel is the first of its frame.
- eol  out  1  pixel is the last of its line.
- valid  out  1  pixel valid.
- out_ready  in  1  consumer accepts the pixel.
- sync_err  out  1  one-cycle pulse on a framing error.
- err_count  out  ERR_CNT_W  framing-error count.

## Operation
- Phase register has four values, P0 to P3. A byte holding buffer `hold` stores up to 3 bytes. The output stage is a single register holding r, g, b, sof, eol and valid.
- Output slot free: `free = !valid | out_ready`.
- in_stream_tready = aresetn & free & (phase != P3). It is combinational.
- Words arrive as w0, w1, w2. The line byte stream is g0 b0 r0 g1 b1 r1 g2 b2 r2 g3 b3 r3.
- P0, word accepted: pixel = {g=B0, b=B1, r=B2}; hold = B3; next phase P1.
- P1, word accepted: pixel = {g=hold, b=B0, r=B1}; hold = {B2, B3}; next phase P2.
- P2, word accepted: pixel = {g=hold[0], b=hold[1], r=B0}; hold = {B1, B2, B3}; next phase P3.
- P3, when free: pixel = {g=hold[0], b=hold[1], r=hold[2]}; next phase P0. No input is consumed in P3.
- sof output = tuser of the word that produced pixel 0. It is 0 for every other pixel.
- tlast accepted in P2: pixel2 eol=0, pixel3 eol=1.
- tuser on a word accepted in P1 or P2 (resynchronise):
  - discard hold;
  - decode the word as P0 with sof=1; next phase P1;
  - pulse sync_err.
- tlast on a word accepted in P0 or P1 (line width not a multiple of 4):
  - emit that word's pixel with eol=1;
  - discard hold; next phase P0;
  - pulse sync_err.
- Both tuser and tlast on one word: apply the tuser resync first, then the tlast check against P0. The result is one pixel with sof=1 and eol=1, one sync_err pulse, and an increment of 1.
- Output register holds its value while valid & !out_ready.

## Timing
- Reset values:
  - phase = P0, hold = 0;
  - r = g = b = 0, sof = eol = valid = 0;
  - sync_err = 0, err_count = 0;
  - in_stream_tready = 0 while aresetn = 0.
- Latency: a word accepted at edge N gives its pixel with valid=1 after edge N; it is visible in cycle N+1.
- P3 pixel appears one cycle after the w2 pixel, if out_ready stays high.
- Throughput with out_ready held high: 4 pixels per 4 cycles, 3 words per 4 cycles. in_stream_tready is low one cycle in four.
- Reset mid-group: partial hold bytes are lost. The first word after reset is decoded as P0.
- Back-pressure: while out_ready=0 with valid=1, in_stream_tready=0 and phase and hold are frozen.

## Configuration
- PIXEL_UNPACKER_ERR_CNT_EN defined: err_count increments on each sync_err pulse and saturates at all-ones. It is cleared only by reset.
- PIXEL_UNPACKER_ERR_CNT_EN undefined: err_count is tied to 0 and no counter logic is built. sync_err is unaffected.

## Test plan
- Nominal line: words 0x03020100 (tuser=1), 0x07060504, 0x0B0A0908 (tlast=1); out_ready=1.
  - Required pixels as (r, g, b): (02,00,01) sof=1; (05,03,04); (08,06,07); (0B,09,0A) eol=1.
  - in_stream_tready is low in the cycle after w2.
- Back-pressure: same stimulus with out_ready toggled 1,0,0,1,...
  - Pixel sequence is identical.
  - No word is accepted while valid & !out_ready.
- tuser resync: send 0x03020100, then 0x77665544 with tuser=1.
  - Second pixel = (66,44,55) with sof=1.
  - sync_err pulses once; err_count=1 when the macro is enabled.
- Early tlast: send 0x03020100 with tlast=1 in P0.
  - One pixel (02,00,01) with eol=1.
  - Phase returns to P0; sync_err pulses.
- Reset mid-group: send w0 and w1, assert aresetn=0 for 1 cycle, then send the nominal line.
  - All outputs are 0 during reset.
  - Output afterwards is exactly the four nominal pixels.
- Counter saturation, with ERR_CNT_W=2 and the macro defined: 5 early-tlast errors give err_count 1, 2, 3, 3, 3.
  - With the macro undefined, err_count stays 0.
